// File: rtl/feed_forward_weight_loader.sv
// Byte-stream weight loader: checks a sync byte, assembles little-endian words and
// writes every weight of layer 0 then layer 1 into the feed-forward network.
module feed_forward_weight_loader #(
    parameter int          BITS_PER_WORD       = 32,
    parameter int          L0_N                = 3,
    parameter int          L0_M                = 2,
    parameter int          L1_N                = 3,
    parameter int          L1_M                = 1,
    parameter int          CLOG2_MAX_WEIGHTS_N = 2,
    parameter int          CLOG2_MAX_WEIGHTS_M = 2,
    parameter logic [7:0]  SYNC_BYTE           = 8'hA5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic                           byte_ready,
    output logic                           weights_en,
    output logic                           weights_layer_address,
    output logic [CLOG2_MAX_WEIGHTS_N-1:0] weights_n_address,
    output logic [CLOG2_MAX_WEIGHTS_M-1:0] weights_m_address,
    output logic [BITS_PER_WORD-1:0]       weights_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int BYTES = BITS_PER_WORD / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, LOAD, WRITE} state_t;

    state_t                         state_reg, state_next;
    logic                           layer_reg;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] n_reg;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] m_reg;
    logic [BCW-1:0]                 byte_cnt_reg;
    logic [BITS_PER_WORD-1:0]       word_reg;
    logic [BITS_PER_WORD-1:0]       word_next;
    logic                           layer_out_reg;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] n_out_reg;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] m_out_reg;
    logic [BITS_PER_WORD-1:0]       data_out_reg;
    logic                           done_reg;
    logic                           error_reg;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] n_max;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] m_max;
    logic                           last_n;
    logic                           last_m;
    logic                           last_weight;

    // Drop the incoming byte into its little-endian lane of the partial word.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (byte_cnt_reg == BCW'(gi)) ? byte_data
                                                                     : word_reg[gi*8 +: 8];
        end
    endgenerate

    assign n_max       = layer_reg ? CLOG2_MAX_WEIGHTS_N'(L1_N - 1) : CLOG2_MAX_WEIGHTS_N'(L0_N - 1);
    assign m_max       = layer_reg ? CLOG2_MAX_WEIGHTS_M'(L1_M - 1) : CLOG2_MAX_WEIGHTS_M'(L0_M - 1);
    assign last_n      = (n_reg == n_max);
    assign last_m      = (m_reg == m_max);
    assign last_weight = layer_reg && last_n && last_m;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) state_next = SYNC;
            end
            SYNC: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = (byte_data == SYNC_BYTE) ? LOAD : IDLE;
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_cnt_reg == LAST_BYTE) state_next = WRITE;
            end
            WRITE: begin
                state_next = last_weight ? IDLE : LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            layer_reg     <= 1'b0;
            n_reg         <= '0;
            m_reg         <= '0;
            byte_cnt_reg  <= '0;
            word_reg      <= '0;
            layer_out_reg <= 1'b0;
            n_out_reg     <= '0;
            m_out_reg     <= '0;
            data_out_reg  <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        error_reg    <= 1'b0;
                        layer_reg    <= 1'b0;
                        n_reg        <= '0;
                        m_reg        <= '0;
                        byte_cnt_reg <= '0;
                        word_reg     <= '0;
                    end
                end
                SYNC: begin
                    if (byte_valid && byte_data != SYNC_BYTE) error_reg <= 1'b1;
                end
                LOAD: begin
                    if (byte_valid) begin
                        word_reg <= word_next;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            byte_cnt_reg  <= '0;
                            // Output registers are only touched here so they hold between writes.
                            data_out_reg  <= word_next;
                            layer_out_reg <= layer_reg;
                            n_out_reg     <= n_reg;
                            m_out_reg     <= m_reg;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (last_weight) done_reg <= 1'b1;
                    if (!last_m) begin
                        m_reg <= m_reg + 1'b1;
                    end else begin
                        m_reg <= '0;
                        if (!last_n) begin
                            n_reg <= n_reg + 1'b1;
                        end else begin
                            n_reg     <= '0;
                            layer_reg <= ~layer_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign weights_en            = (state_reg == WRITE);
    assign weights_layer_address = layer_out_reg;
    assign weights_n_address     = n_out_reg;
    assign weights_m_address     = m_out_reg;
    assign weights_data          = data_out_reg;
    assign busy                  = (state_reg != IDLE);
    assign done                  = done_reg;
    assign error                 = error_reg;

endmodule

// File: tb/tb_feed_forward_weight_loader.sv
// Randomized bench for feed_forward_weight_loader against a list-based model of the
// expected write sequence (address order and little-endian word assembly).
module tb_feed_forward_weight_loader;

    localparam int L0_N = 3, L0_M = 2, L1_N = 3, L1_M = 1;
    localparam int NW   = L0_N * L0_M + L1_N * L1_M;

    logic        clk = 1'b0;
    logic        reset_n, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, weights_en, weights_layer_address;
    logic [1:0]  weights_n_address, weights_m_address;
    logic [31:0] weights_data;
    logic        busy, done, error;

    feed_forward_weight_loader dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
        .byte_valid            (byte_valid),
        .byte_data             (byte_data),
        .byte_ready            (byte_ready),
        .weights_en            (weights_en),
        .weights_layer_address (weights_layer_address),
        .weights_n_address     (weights_n_address),
        .weights_m_address     (weights_m_address),
        .weights_data          (weights_data),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic [31:0] ld_words[NW];
    int  done_cnt = 0;
    bit  prev_final_write = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: record every write, byte_ready must be low in WRITE, done must trail the final write.
    always @(negedge clk) begin
        if (weights_en) begin
            got_q.push_back({weights_layer_address, weights_n_address, weights_m_address, weights_data});
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
        end
        if (done) begin
            done_cnt++;
            check("done_after_last_write", 64'(prev_final_write), 64'd1);
        end
        prev_final_write = weights_en && weights_layer_address == 1'b1 &&
                           weights_n_address == 2'(L1_N - 1) && weights_m_address == 2'(L1_M - 1);
    end

    function automatic void build_expected();
        int idx = 0;
        exp_q.delete();
        for (int l = 0; l < 2; l++)
            for (int n = 0; n < (l == 0 ? L0_N : L1_N); n++)
                for (int m = 0; m < (l == 0 ? L0_M : L1_M); m++) begin
                    exp_q.push_back({1'(l), 2'(n), 2'(m), ld_words[idx]});
                    idx++;
                end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit sent = 1'b0;
        int guard = 0;
        while (!sent) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (rnd && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) sent = 1'b1;
            end
            guard++;
            if (guard > 200) begin
                $display("FAIL send_byte_timeout: got byte_ready=%0b expected 1", byte_ready);
                $fatal(1, "byte stream stalled");
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        start      = 1'b1;
        byte_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    64'(weights_en), 64'd0);
        check({tag, "_addr"},  64'({weights_layer_address, weights_n_address, weights_m_address}), 64'd0);
        check({tag, "_data"},  64'(weights_data), 64'd0);
        check({tag, "_flags"}, 64'({byte_ready, busy, done, error}), 64'd0);
    endtask

    // One load; start is pulsed again alongside data byte pulse_at; abort_after>0 stops after that many writes.
    task automatic do_load(input bit rnd, input int pulse_at, input int abort_after, output bit aborted);
        int guard = 0;
        aborted = 1'b0;
        build_expected();
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        send_byte(8'hA5, rnd);
        for (int j = 0; j < NW * 4; j++) begin
            logic [31:0] w;
            if (j == pulse_at) start = 1'b1;
            w = ld_words[j / 4];
            send_byte(w[8 * (j % 4) +: 8], rnd);
            if (abort_after > 0 && got_q.size() >= abort_after) begin
                aborted = 1'b1;
                return;
            end
        end
        @(negedge clk); #1;
        byte_valid = 1'b0;
        while (done_cnt == 0 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("idle_after_load", 64'({busy, error, byte_ready}), 64'd0);
        check("write_count", 64'(got_q.size()), 64'(NW));
        for (int i = 0; i < NW && i < got_q.size(); i++)
            check($sformatf("write_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        bit ab;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 reset_n = 1'b1;

        // Sequential words 1..NW, valid held high.
        for (int i = 0; i < NW; i++) ld_words[i] = 32'(i + 1);
        do_load(1'b0, -1, 0, ab);

        // Fixed-point boundary words plus random fill.
        ld_words[0] = 32'h0001_0000;
        ld_words[1] = 32'hFFFF_FFFF;
        for (int i = 2; i < NW; i++) ld_words[i] = $urandom;
        do_load(1'b0, -1, 0, ab);

        // Bad sync byte, then a clean recovery load.
        pulse_start();
        got_q.delete();
        send_byte(8'h5A, 1'b0);
        @(negedge clk); #1;
        byte_valid = 1'b0;
        check("bad_sync_error", 64'(error), 64'd1);
        check("bad_sync_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("bad_sync_no_writes", 64'(got_q.size()), 64'd0);
        for (int i = 0; i < NW; i++) ld_words[i] = $urandom;
        do_load(1'b0, -1, 0, ab);

        // Randomly gapped byte_valid.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NW; i++) ld_words[i] = $urandom;
            do_load(1'b1, -1, 0, ab);
        end

        // start pulsed mid-load is ignored.
        for (int i = 0; i < NW; i++) ld_words[i] = $urandom | 32'h1;
        do_load(1'b0, 10, 0, ab);

        // Reset after the third write, then a full fresh load.
        for (int i = 0; i < NW; i++) ld_words[i] = $urandom | 32'h100;
        do_load(1'b0, -1, 3, ab);
        check("abort_reached", 64'(ab), 64'd1);
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk); #1;
        check_all_zero("midload_reset");
        check("writes_before_reset", 64'(got_q.size()), 64'd3);
        reset_n = 1'b1;
        for (int i = 0; i < NW; i++) ld_words[i] = $urandom;
        do_load(1'b1, -1, 0, ab);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
